// File: rtl/ucsbece154a_defines.sv
// Shared encodings for the multicycle RV32I controller: states, opcodes and datapath select codes.
package ucsbece154a_defines;

  localparam int unsigned STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10,
    LUI      = 4'd11
  } statetype_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;
  localparam logic [1:0] RES_IMMEXT    = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

endpackage

// File: rtl/ucsbece154a_aludec.sv
// Combinational ALU decoder: maps ALUOp plus instruction funct fields to an ALU operation.
module ucsbece154a_aludec
  import ucsbece154a_defines::*;
(
  input  aluop_t     aluop_i,
  input  logic [2:0] funct3_i,
  input  logic       op5_i,
  input  logic       funct7b5_i,
  output logic [2:0] alucontrol_c
);

  always_comb begin
    alucontrol_c = ALU_ADD;
    case (aluop_i)
      ALUOP_ADD: alucontrol_c = ALU_ADD;
      ALUOP_SUB: alucontrol_c = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3_i)
          3'b000:  alucontrol_c = (op5_i & funct7b5_i) ? ALU_SUB : ALU_ADD;
          3'b010:  alucontrol_c = ALU_SLT;
          3'b110:  alucontrol_c = ALU_OR;
          3'b111:  alucontrol_c = ALU_AND;
          default: alucontrol_c = ALU_ADD;
        endcase
      end
      default: alucontrol_c = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/ucsbece154a_mc_controller.sv
// Multicycle control unit: Moore main FSM, immediate decode and ALU decoder for a shared-memory datapath.
module ucsbece154a_mc_controller
  import ucsbece154a_defines::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  input  logic       zero_i,
  output logic       PCWrite_o,
  output logic       AdrSrc_o,
  output logic       MemWrite_o,
  output logic       IRWrite_o,
  output logic       RegWrite_o,
  output logic [1:0] ResultSrc_o,
  output logic [1:0] ALUSrcA_o,
  output logic [1:0] ALUSrcB_o,
  output logic [2:0] ALUControl_o,
  output logic [2:0] ImmSrc_o,
  output logic [3:0] state_o
);

  statetype_t state_q, state_d;
  aluop_t     aluop_c;
  logic       pcupdate_c, branch_c, irwrite_c, regwrite_c, memwrite_c;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = FETCH;
    aluop_c     = ALUOP_ADD;
    pcupdate_c  = 1'b0;
    branch_c    = 1'b0;
    irwrite_c   = 1'b0;
    regwrite_c  = 1'b0;
    memwrite_c  = 1'b0;
    AdrSrc_o    = 1'b0;
    ResultSrc_o = RES_ALUOUT;
    ALUSrcA_o   = SRCA_PC;
    ALUSrcB_o   = SRCB_RD2;
    case (state_q)
      FETCH: begin
        state_d     = DECODE;
        irwrite_c   = 1'b1;
        pcupdate_c  = 1'b1;
        ALUSrcB_o   = SRCB_FOUR;
        ResultSrc_o = RES_ALURESULT;
      end
      DECODE: begin
        case (op_i)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_R:         state_d = EXECUTER;
          OP_I:         state_d = EXECUTEI;
          OP_JAL:       state_d = JAL;
          OP_BR:        state_d = BEQ;
          OP_LUI:       state_d = LUI;
          default:      state_d = FETCH;
        endcase
        // Branch target is precomputed here from OldPC + ImmExt
        ALUSrcA_o = SRCA_OLDPC;
        ALUSrcB_o = SRCB_IMM;
      end
      MEMADR: begin
        state_d   = op_i[5] ? MEMWRITE : MEMREAD;
        ALUSrcA_o = SRCA_RD1;
        ALUSrcB_o = SRCB_IMM;
      end
      MEMREAD: begin
        state_d  = MEMWB;
        AdrSrc_o = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc_o   = 1'b1;
        memwrite_c = 1'b1;
      end
      MEMWB: begin
        ResultSrc_o = RES_DATA;
        regwrite_c  = 1'b1;
      end
      EXECUTER: begin
        state_d   = ALUWB;
        ALUSrcA_o = SRCA_RD1;
        aluop_c   = ALUOP_FUNCT;
      end
      EXECUTEI: begin
        state_d   = ALUWB;
        ALUSrcA_o = SRCA_RD1;
        ALUSrcB_o = SRCB_IMM;
        aluop_c   = ALUOP_FUNCT;
      end
      ALUWB: regwrite_c = 1'b1;
      JAL: begin
        state_d    = ALUWB;
        ALUSrcA_o  = SRCA_OLDPC;
        ALUSrcB_o  = SRCB_FOUR;
        pcupdate_c = 1'b1;
      end
      BEQ: begin
        ALUSrcA_o = SRCA_RD1;
        aluop_c   = ALUOP_SUB;
        branch_c  = 1'b1;
      end
      LUI: begin
        ResultSrc_o = RES_IMMEXT;
        regwrite_c  = 1'b1;
      end
      default: state_d = FETCH;
    endcase
  end

  // Enables are gated by reset directly so an abort suppresses writes without waiting for an edge
  assign PCWrite_o  = reset & (pcupdate_c | (branch_c & (zero_i ^ funct3_i[0])));
  assign IRWrite_o  = reset & irwrite_c;
  assign RegWrite_o = reset & regwrite_c;
  assign MemWrite_o = reset & memwrite_c;
  assign state_o    = 4'(state_q);

  always_comb begin
    ImmSrc_o = IMM_I;
    case (op_i)
      OP_SW:   ImmSrc_o = IMM_S;
      OP_BR:   ImmSrc_o = IMM_B;
      OP_JAL:  ImmSrc_o = IMM_J;
      OP_LUI:  ImmSrc_o = IMM_U;
      default: ImmSrc_o = IMM_I;
    endcase
  end

  ucsbece154a_aludec u_aludec (
    .aluop_i     (aluop_c),
    .funct3_i    (funct3_i),
    .op5_i       (op_i[5]),
    .funct7b5_i  (funct7b5_i),
    .alucontrol_c(ALUControl_o)
  );

endmodule

// File: tb/tb_ucsbece154a_mc_controller.sv
// Self-checking bench: per-instruction state sequences and per-state control tables checked every cycle.
module tb_ucsbece154a_mc_controller;
  import ucsbece154a_defines::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op_i;
  logic [2:0] funct3_i;
  logic       funct7b5_i;
  logic       zero_i;
  logic       PCWrite_o, AdrSrc_o, MemWrite_o, IRWrite_o, RegWrite_o;
  logic [1:0] ResultSrc_o, ALUSrcA_o, ALUSrcB_o;
  logic [2:0] ALUControl_o, ImmSrc_o;
  logic [3:0] state_o;

  ucsbece154a_mc_controller dut (
    .clk(clk), .reset(reset), .op_i(op_i), .funct3_i(funct3_i), .funct7b5_i(funct7b5_i),
    .zero_i(zero_i), .PCWrite_o(PCWrite_o), .AdrSrc_o(AdrSrc_o), .MemWrite_o(MemWrite_o),
    .IRWrite_o(IRWrite_o), .RegWrite_o(RegWrite_o), .ResultSrc_o(ResultSrc_o),
    .ALUSrcA_o(ALUSrcA_o), .ALUSrcB_o(ALUSrcB_o), .ALUControl_o(ALUControl_o),
    .ImmSrc_o(ImmSrc_o), .state_o(state_o)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model context, written by the stimulus process and read by the compare process
  logic chk_en = 1'b0;
  logic in_rst = 1'b1;
  int   cur_cls = 0;
  int   cur_step = 0;

  localparam int C_LW = 0, C_SW = 1, C_R = 2, C_I = 3, C_JAL = 4, C_BR = 5, C_LUI = 6, C_ILL = 7;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int classify(input logic [6:0] op);
    case (op)
      7'b0000011: return C_LW;
      7'b0100011: return C_SW;
      7'b0110011: return C_R;
      7'b0010011: return C_I;
      7'b1101111: return C_JAL;
      7'b1100011: return C_BR;
      7'b0110111: return C_LUI;
      default:    return C_ILL;
    endcase
  endfunction

  function automatic int cls_len(input int c);
    case (c)
      C_LW:               return 5;
      C_SW, C_R, C_I, C_JAL: return 4;
      C_BR, C_LUI:        return 3;
      default:            return 2;
    endcase
  endfunction

  function automatic statetype_t state_at(input int c, input int step);
    statetype_t seq[5];
    seq[0] = FETCH; seq[1] = DECODE; seq[2] = FETCH; seq[3] = FETCH; seq[4] = FETCH;
    case (c)
      C_LW:  begin seq[2] = MEMADR; seq[3] = MEMREAD; seq[4] = MEMWB; end
      C_SW:  begin seq[2] = MEMADR; seq[3] = MEMWRITE; end
      C_R:   begin seq[2] = EXECUTER; seq[3] = ALUWB; end
      C_I:   begin seq[2] = EXECUTEI; seq[3] = ALUWB; end
      C_JAL: begin seq[2] = JAL; seq[3] = ALUWB; end
      C_BR:  seq[2] = BEQ;
      C_LUI: seq[2] = LUI;
      default: ;
    endcase
    return seq[step];
  endfunction

  // Expected outputs derived from the per-state control table
  statetype_t es;
  logic       e_pcu, e_br, e_ir, e_rw, e_mw, e_adr, e_pcw;
  logic [1:0] e_a, e_b, e_res;
  int         e_aluop;
  logic [2:0] e_alu, e_imm;

  always @(negedge clk) begin
    if (chk_en) begin
      es = in_rst ? FETCH : state_at(cur_cls, cur_step);
      {e_pcu, e_br, e_ir, e_rw, e_mw, e_adr} = '0;
      e_a = 2'b00; e_b = 2'b00; e_res = 2'b00; e_aluop = 0;
      case (es)
        FETCH:    begin e_ir = 1; e_b = 2'b10; e_res = 2'b10; e_pcu = 1; end
        DECODE:   begin e_a = 2'b01; e_b = 2'b01; end
        MEMADR:   begin e_a = 2'b10; e_b = 2'b01; end
        MEMREAD:  e_adr = 1;
        MEMWRITE: begin e_adr = 1; e_mw = 1; end
        MEMWB:    begin e_res = 2'b01; e_rw = 1; end
        EXECUTER: begin e_a = 2'b10; e_aluop = 2; end
        EXECUTEI: begin e_a = 2'b10; e_b = 2'b01; e_aluop = 2; end
        ALUWB:    e_rw = 1;
        JAL:      begin e_a = 2'b01; e_b = 2'b10; e_pcu = 1; end
        BEQ:      begin e_a = 2'b10; e_aluop = 1; e_br = 1; end
        LUI:      begin e_res = 2'b11; e_rw = 1; end
        default:  ;
      endcase
      if (e_aluop == 1) e_alu = 3'b001;
      else if (e_aluop == 2) begin
        case (funct3_i)
          3'b000:  e_alu = (op_i[5] && funct7b5_i) ? 3'b001 : 3'b000;
          3'b010:  e_alu = 3'b101;
          3'b110:  e_alu = 3'b011;
          3'b111:  e_alu = 3'b010;
          default: e_alu = 3'b000;
        endcase
      end else e_alu = 3'b000;
      e_imm = (op_i == 7'b0100011) ? 3'b001 : (op_i == 7'b1100011) ? 3'b010 :
              (op_i == 7'b1101111) ? 3'b011 : (op_i == 7'b0110111) ? 3'b100 : 3'b000;
      e_pcw = e_pcu | (e_br & (zero_i ^ funct3_i[0]));
      if (in_rst) begin e_pcw = 0; e_ir = 0; e_rw = 0; e_mw = 0; end
      check("state", 32'(state_o), 32'(es));
      check("enables", 32'({PCWrite_o, IRWrite_o, RegWrite_o, MemWrite_o, AdrSrc_o}),
            32'({e_pcw, e_ir, e_rw, e_mw, e_adr}));
      check("selects", 32'({ResultSrc_o, ALUSrcA_o, ALUSrcB_o}), 32'({e_res, e_a, e_b}));
      check("alucontrol", 32'(ALUControl_o), 32'(e_alu));
      check("immsrc", 32'(ImmSrc_o), 32'(e_imm));
    end
  end

  // Runs one instruction from its FETCH cycle; caller is just after a rising edge.
  // zmode 0/1 forces zero_i, 2 randomizes it. stop_at >= 0 returns mid-step without advancing.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                           input int zmode, input int stop_at,
                           output int mw_n, output int rw_n, output int pcw_n,
                           output logic [2:0] alu_step2);
    int len;
    mw_n = 0; rw_n = 0; pcw_n = 0; alu_step2 = 3'b000;
    op_i = op; funct3_i = f3; funct7b5_i = f7;
    cur_cls = classify(op);
    len = cls_len(cur_cls);
    for (int s = 0; s < len; s++) begin
      cur_step = s;
      zero_i = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      #1;
      mw_n += int'(MemWrite_o);
      rw_n += int'(RegWrite_o);
      if (s >= 2) pcw_n += int'(PCWrite_o);
      if (s == 2) alu_step2 = ALUControl_o;
      if (s == stop_at) return;
      @(posedge clk); #1;
    end
  endtask

  logic [6:0] legal_ops [7];
  int mw, rw, pcw;
  logic [2:0] alu2;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    legal_ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                  7'b1101111, 7'b1100011, 7'b0110111};
    reset = 1'b0; op_i = 7'b0110011; funct3_i = 3'b000; funct7b5_i = 1'b0; zero_i = 1'b0;
    in_rst = 1'b1; chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", 32'(state_o), 32'(FETCH));
    check("rst_writes", 32'({PCWrite_o, IRWrite_o, RegWrite_o, MemWrite_o}), 32'(4'b0000));
    check("rst_srcb", 32'(ALUSrcB_o), 32'(2'b10));
    reset = 1'b1; in_rst = 1'b0; cur_step = 0;
    #1;
    check("first_fetch_ir_pc", 32'({IRWrite_o, PCWrite_o}), 32'(2'b11));

    run_instr(7'b0000011, 3'b010, 1'b0, 2, -1, mw, rw, pcw, alu2);
    check("lw_regwrite_cycles", 32'(rw), 32'(1));
    run_instr(7'b0100011, 3'b010, 1'b0, 2, -1, mw, rw, pcw, alu2);
    check("sw_memwrite_cycles", 32'(mw), 32'(1));
    run_instr(7'b0110011, 3'b000, 1'b1, 2, -1, mw, rw, pcw, alu2);
    check("sub_alucontrol", 32'(alu2), 32'(3'b001));
    check("sub_regwrite_cycles", 32'(rw), 32'(1));
    run_instr(7'b1100011, 3'b000, 1'b0, 1, -1, mw, rw, pcw, alu2);
    check("beq_taken_pcwrite", 32'(pcw), 32'(1));
    run_instr(7'b1100011, 3'b000, 1'b0, 0, -1, mw, rw, pcw, alu2);
    check("beq_not_taken_pcwrite", 32'(pcw), 32'(0));
    run_instr(7'b1100011, 3'b001, 1'b0, 0, -1, mw, rw, pcw, alu2);
    check("bne_taken_pcwrite", 32'(pcw), 32'(1));
    run_instr(7'b1111111, 3'b000, 1'b0, 2, -1, mw, rw, pcw, alu2);
    check("illegal_no_writes", 32'(mw + rw), 32'(0));

    for (int n = 0; n < 400; n++) begin
      logic [6:0] op;
      if ($urandom_range(0, 7) == 0) begin
        do op = 7'($urandom_range(0, 127)); while (classify(op) != C_ILL);
      end else op = legal_ops[$urandom_range(0, 6)];
      run_instr(op, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 2, -1,
                mw, rw, pcw, alu2);
    end

    // Abort during the load write-back: RegWrite must drop without a clock edge
    run_instr(7'b0000011, 3'b010, 1'b0, 2, 4, mw, rw, pcw, alu2);
    check("memwb_regwrite_before_abort", 32'(RegWrite_o), 32'(1));
    reset = 1'b0; in_rst = 1'b1;
    #1;
    check("abort_regwrite_async", 32'(RegWrite_o), 32'(0));
    check("abort_state_async", 32'(state_o), 32'(FETCH));
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1; in_rst = 1'b0; cur_step = 0;
    run_instr(7'b0010011, 3'b110, 1'b0, 2, -1, mw, rw, pcw, alu2);
    check("restart_i_regwrite_cycles", 32'(rw), 32'(1));
    run_instr(7'b0110111, 3'b000, 1'b0, 2, -1, mw, rw, pcw, alu2);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
